fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch queue. It sits between the instruction memory port (IM_*) and the IF/ID pipeline register. It issues sequential word reads ahead of the decoder and buffers returned instructions with their PC tags. It presents them to the pipeline over a valid/ready handshake and flushes on branch/jump redirect. It replaces the bare PC-to-IM_address connection, generalising address width, data width and buffer depth.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue_sync_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: default widths, reset PC and the queue entry layout.
// Used by fetch_queue, and intended for the pc and regwall blocks as well.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 10;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned FETCH_DEPTH  = 4;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  // One buffered instruction together with the word address it was fetched from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: circular buffer with count, flush, and synchronous active-high reset.
// DEPTH must be a power of two, so the pointers wrap naturally.
module sync_fifo #(
  parameter  int unsigned WIDTH = 42,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage, pointers and occupancy; flush empties the buffer but keeps stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared on reset because the head entry is visible on
      // the outputs even when empty, and it must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetcher with a DEPTH-entry queue,
// valid/ready delivery to IF/ID and redirect flush.
// Optional feature macro FETCH_BYPASS_EN: forwards a response straight to the
// consumer when the queue is empty (1-cycle fetch-to-valid instead of 2).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter  int unsigned       DATA_W   = FETCH_DATA_W,
  parameter  int unsigned       DEPTH    = FETCH_DEPTH,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_enable,
  output logic              im_read,
  output logic              im_write,
  output logic [ADDR_W-1:0] im_address,
  input  logic [DATA_W-1:0] im_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [CNT_W-1:0]  fill_level
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occupancy;
  logic              w_issue;
  logic              w_bypass;
  logic              w_head_valid;
  logic              w_push;
  logic              w_pop;
  entry_t            w_head;
  entry_t            w_resp;

  // Queued entries plus the read still in flight; issue only while both fit.
  assign w_occupancy  = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
  assign w_issue      = ~rst & ~redirect & (w_occupancy < (CNT_W + 1)'(DEPTH));
  assign w_head_valid = (w_count != '0);
  assign w_resp       = '{pc: r_inflight_pc, data: im_data};

`ifdef FETCH_BYPASS_EN
  assign w_bypass = ~rst & r_inflight & ~w_head_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response accepted this cycle never enters storage.
  assign w_push = r_inflight & ~(w_bypass & inst_ready);
  assign w_pop  = w_head_valid & inst_ready;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata (w_resp),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  // Fetch PC and in-flight tracking; redirect drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Output decode; everything is forced to its reset value while rst is high.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    im_enable  = ~rst;
    im_write   = 1'b0;
    im_read    = w_issue;
    im_address = rst ? RESET_PC : r_fetch_pc;
    inst_valid = 1'b0;
    inst_data  = '0;
    inst_pc    = '0;
    fill_level = '0;
    if (!rst) begin
      inst_valid = w_head_valid | w_bypass;
      inst_data  = w_bypass ? im_data : w_head.data;
      inst_pc    = w_bypass ? r_inflight_pc : w_head.pc;
      fill_level = w_count;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default parameters).
// A per-cycle vector table checks handshake/flow signals; a scoreboard checks
// every issued address and every delivered {pc, data} pair in order.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              im_enable, im_read, im_write;
  logic [ADDR_W-1:0] im_address;
  logic [DATA_W-1:0] im_data = 32'hDEAD_BEEF;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid, inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [2:0]        fill_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .im_enable   (im_enable),
    .im_read     (im_read),
    .im_write    (im_write),
    .im_address  (im_address),
    .im_data     (im_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .fill_level  (fill_level)
  );

  // Instruction memory: one-cycle read latency, data = 0xA000_0000 + address.
  always @(posedge clk)
    im_data <= im_read ? (32'hA000_0000 + {22'd0, im_address}) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected entries are queued when a read is issued and popped
  // when the consumer takes an instruction; redirect and reset drop them all.
  fetch_entry_t      sb_q[$];
  logic [ADDR_W-1:0] exp_fetch_pc = '0;
  bit                sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on) begin
      if (rst) begin
        sb_q.delete();
        exp_fetch_pc = '0;
      end else begin
        if (inst_valid && inst_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: delivered pc %h with nothing outstanding", inst_pc);
          end else begin
            fetch_entry_t e;
            e = sb_q.pop_front();
            check("sb_pc", {22'd0, inst_pc}, {22'd0, e.pc});
            check("sb_data", inst_data, e.data);
          end
        end
        if (redirect) begin
          sb_q.delete();
          exp_fetch_pc = redirect_pc;
        end else if (im_read) begin
          check("sb_issue_addr", {22'd0, im_address}, {22'd0, exp_fetch_pc});
          sb_q.push_back('{pc: exp_fetch_pc, data: 32'hA000_0000 + {22'd0, exp_fetch_pc}});
          exp_fetch_pc++;
        end
      end
    end
  end

  typedef struct {
    logic              rst;
    logic              ready;
    logic              redir;
    logic [ADDR_W-1:0] rpc;
    logic              e_read;
    logic [ADDR_W-1:0] e_addr;
    logic              e_valid;
    logic [ADDR_W-1:0] e_pc;
    logic [2:0]        e_fill;
  } vec_t;

  function automatic vec_t v(logic r, logic rdy, logic rd, logic [ADDR_W-1:0] rp,
                             logic er, logic [ADDR_W-1:0] ea, logic ev,
                             logic [ADDR_W-1:0] ep, logic [2:0] ef);
    vec_t t;
    t = '{rst: r, ready: rdy, redir: rd, rpc: rp, e_read: er, e_addr: ea,
          e_valid: ev, e_pc: ep, e_fill: ef};
    return t;
  endfunction

  vec_t tbl[30];

  initial begin
    int k;
    rst         = 1'b1;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_im_read",    {31'd0, im_read},    0);
    check("rst_im_enable",  {31'd0, im_enable},  0);
    check("rst_im_write",   {31'd0, im_write},   0);
    check("rst_im_address", {22'd0, im_address}, 0);
    check("rst_inst_valid", {31'd0, inst_valid}, 0);
    check("rst_inst_data",  inst_data,           0);
    check("rst_inst_pc",    {22'd0, inst_pc},    0);
    check("rst_fill",       {29'd0, fill_level}, 0);
    sb_on = 1'b1;

    //            rst rdy red rpc      read addr    valid pc     fill
    tbl[0]  = v(0, 1, 0, 10'h000,  1, 10'h000,  0, 10'h000, 0);
    tbl[1]  = v(0, 1, 0, 10'h000,  1, 10'h001,  0, 10'h000, 0);
    tbl[2]  = v(0, 1, 0, 10'h000,  1, 10'h002,  1, 10'h000, 1);
    tbl[3]  = v(0, 1, 0, 10'h000,  1, 10'h003,  1, 10'h001, 1);
    tbl[4]  = v(0, 0, 0, 10'h000,  1, 10'h004,  1, 10'h002, 1);
    tbl[5]  = v(0, 0, 0, 10'h000,  1, 10'h005,  1, 10'h002, 2);
    tbl[6]  = v(0, 0, 0, 10'h000,  0, 10'h006,  1, 10'h002, 3);
    tbl[7]  = v(0, 0, 0, 10'h000,  0, 10'h006,  1, 10'h002, 4);
    tbl[8]  = v(0, 0, 0, 10'h000,  0, 10'h006,  1, 10'h002, 4);
    tbl[9]  = v(0, 1, 0, 10'h000,  0, 10'h006,  1, 10'h002, 4);
    tbl[10] = v(0, 1, 0, 10'h000,  1, 10'h006,  1, 10'h003, 3);
    tbl[11] = v(0, 1, 0, 10'h000,  1, 10'h007,  1, 10'h004, 2);
    tbl[12] = v(0, 0, 0, 10'h000,  1, 10'h008,  1, 10'h005, 2);
    tbl[13] = v(0, 0, 1, 10'h100,  0, 10'h009,  1, 10'h005, 3);
    tbl[14] = v(0, 1, 0, 10'h000,  1, 10'h100,  0, 10'h000, 0);
    tbl[15] = v(0, 1, 0, 10'h000,  1, 10'h101,  0, 10'h000, 0);
    tbl[16] = v(0, 1, 0, 10'h000,  1, 10'h102,  1, 10'h100, 1);
    tbl[17] = v(0, 1, 1, 10'h3FE,  0, 10'h103,  1, 10'h101, 1);
    tbl[18] = v(0, 1, 0, 10'h000,  1, 10'h3FE,  0, 10'h000, 0);
    tbl[19] = v(0, 1, 0, 10'h000,  1, 10'h3FF,  0, 10'h000, 0);
    tbl[20] = v(0, 1, 0, 10'h000,  1, 10'h000,  1, 10'h3FE, 1);
    tbl[21] = v(0, 1, 0, 10'h000,  1, 10'h001,  1, 10'h3FF, 1);
    tbl[22] = v(0, 1, 0, 10'h000,  1, 10'h002,  1, 10'h000, 1);
    tbl[23] = v(0, 0, 0, 10'h000,  1, 10'h003,  1, 10'h001, 1);
    tbl[24] = v(0, 0, 0, 10'h000,  1, 10'h004,  1, 10'h001, 2);
    tbl[25] = v(1, 0, 0, 10'h000,  0, 10'h000,  0, 10'h000, 0);
    tbl[26] = v(0, 1, 0, 10'h000,  1, 10'h000,  0, 10'h000, 0);
    tbl[27] = v(0, 1, 0, 10'h000,  1, 10'h001,  0, 10'h000, 0);
    tbl[28] = v(0, 1, 0, 10'h000,  1, 10'h002,  1, 10'h000, 1);
    tbl[29] = v(0, 1, 0, 10'h000,  1, 10'h003,  1, 10'h001, 1);

`ifndef FETCH_BYPASS_EN
    // Cycle-accurate flow: startup, stall, redirect, address wrap, reset mid-run.
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst         = tbl[i].rst;
      inst_ready  = tbl[i].ready;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      @(negedge clk);
      check($sformatf("c%0d_im_read", i),    {31'd0, im_read},    {31'd0, tbl[i].e_read});
      check($sformatf("c%0d_im_address", i), {22'd0, im_address}, {22'd0, tbl[i].e_addr});
      check($sformatf("c%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_valid});
      check($sformatf("c%0d_fill", i),       {29'd0, fill_level}, {29'd0, tbl[i].e_fill});
      if (tbl[i].e_valid)
        check($sformatf("c%0d_inst_pc", i), {22'd0, inst_pc}, {22'd0, tbl[i].e_pc});
      check($sformatf("c%0d_im_enable", i), {31'd0, im_enable}, {31'd0, ~tbl[i].rst});
    end
`endif

    // Fetch-to-valid latency after reset release, bounded wait.
    @(posedge clk);
    #1;
    rst        = 1'b1;
    redirect   = 1'b0;
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k   = 0;
    @(negedge clk);
    while (!inst_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("fetch_to_valid_cycles", k, LAT);
    check("first_inst_pc",   {22'd0, inst_pc}, 0);
    check("first_inst_data", inst_data, 32'hA000_0000);

    // Steady stream: one instruction per cycle with inst_ready high.
    repeat (6) begin
      @(negedge clk);
      check("stream_valid", {31'd0, inst_valid}, 1);
    end

    @(posedge clk);
    #1;
    sb_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
